// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states,
// instruction field positions and default sizes.
package seq_pkg;

    localparam int PROG_AW_DEF = 4;
    localparam int IW_DEF      = 16;

    // Instruction word layout
    localparam int HALT_BIT = 15;
    localparam int BRZ_BIT  = 14;
    localparam int TGT_MSB  = 13;
    localparam int TGT_LSB  = 10;
    localparam int OP_MSB   = 9;
    localparam int OP_LSB   = 6;
    localparam int OP1_MSB  = 5;
    localparam int OP1_LSB  = 3;
    localparam int OP2_MSB  = 2;
    localparam int OP2_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EVAL,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Program memory: 2**AW words, synchronous write, combinational read.
// Contents are deliberately not reset so a loaded program survives rst_n.
module seq_prog_mem #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words from a local program memory
// and issues op/op1/op2 to the cpu with a valid/ready handshake, looping
// until a HALT instruction completes.
// Build option: define SEQ_BRANCH_EN to honour BRZ (branch to target when
// the cpu Zero flag is set); otherwise bits [14:10] are ignored.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PROG_AW = PROG_AW_DEF,
    parameter int IW      = IW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               load_en,
    input  logic [PROG_AW-1:0] load_addr,
    input  logic [IW-1:0]      load_data,
    output logic [3:0]         op,
    output logic [2:0]         op1,
    output logic [2:0]         op2,
    output logic               op_valid,
    input  logic               op_ready,
    input  logic               z_in,
    output logic [PROG_AW-1:0] pc,
    output logic               busy,
    output logic               done
);

    seq_state_e         state, state_nxt;
    logic [PROG_AW-1:0] pc_nxt;
    logic [IW-1:0]      ir, ir_nxt;
    logic [IW-1:0]      mem_rdata;
    logic               mem_we;

    // Writes only land while idle; a write and start in the same cycle
    // commit before FETCH reads, so the new word is fetched.
    assign mem_we = load_en && (state == S_IDLE);
    assign busy   = (state != S_IDLE);

    seq_prog_mem #(
        .AW (PROG_AW),
        .DW (IW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

`ifndef SEQ_BRANCH_EN
    // Branch fields and the Zero flag have no effect in this build
    logic unused_br;
    assign unused_br = ^{ir[BRZ_BIT:TGT_LSB], z_in};
`endif

    // State, program counter and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next-state, pc update and cpu-facing outputs
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        op_valid  = 1'b0;
        op        = '0;
        op1       = '0;
        op2       = '0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                ir_nxt    = mem_rdata;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                op_valid = 1'b1;
                op       = ir[OP_MSB:OP_LSB];
                op1      = ir[OP1_MSB:OP1_LSB];
                op2      = ir[OP2_MSB:OP2_LSB];
                if (op_ready) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (ir[HALT_BIT]) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_FETCH;
`ifdef SEQ_BRANCH_EN
                    if (ir[BRZ_BIT] && z_in) pc_nxt = PROG_AW'(ir[TGT_MSB:TGT_LSB]);
                    else                     pc_nxt = pc + 1'b1;
`else
                    pc_nxt = pc + 1'b1;
`endif
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled at that same point.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [3:0]  op;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic        op_valid;
    logic        op_ready;
    logic        z_in;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SEQ_BRANCH_EN
    localparam int BR_PC = 4;
`else
    localparam int BR_PC = 1;
`endif

    instr_sequencer #(.PROG_AW(4), .IW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .z_in      (z_in),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [10:0] vec;
    int          beats;
    int          vld_seen;
    logic [6:0]  seq [18];

    assign vec = {op_valid, op, op1, op2};

    initial begin
        rst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = '0;
        load_data = '0; op_ready = 1'b1; z_in = 1'b0;
        #3;
        chk("rst_outs", {27'd0, vec}, 32'h0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- basic program: op=3 op1=1 op2=2, then HALT
        load(4'd0, 16'h00CA);
        load(4'd1, 16'h8000);
        pulse_start();                                    // FETCH pc0
        chk("t1_fetch", {29'd0, busy, op_valid, pc == 4'd0}, 32'b101);
        tick();                                           // ISSUE
        chk("t1_issue", {21'd0, vec}, 32'h4CA);
        tick();                                           // EVAL
        chk("t1_eval_zero", {21'd0, vec}, 32'h0);
        tick();                                           // FETCH pc1
        chk("t1_pc_inc", {28'd0, pc}, 32'd1);
        tick(); tick(); tick();                           // ISSUE, EVAL, DONE
        chk("t1_done", {27'd0, done, pc}, {27'd0, 1'b1, 4'd1});
        tick();                                           // IDLE
        chk("t1_idle", {30'd0, busy, done}, 32'd0);

        // ---- backpressure: hold ISSUE 5 cycles, accept on the 6th
        op_ready = 1'b0;
        pulse_start();
        tick();                                           // ISSUE
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_hold%0d", i), {21'd0, vec}, 32'h4CA);
            if (i == 1) start = 1'b1;                     // ignored while busy
            tick();
            start = 1'b0;
        end
        chk("t2_hold_pc", {28'd0, pc}, 32'd0);
        op_ready = 1'b1;
        chk("t2_sixth", {21'd0, vec}, 32'h4CA);
        tick();                                           // EVAL
        chk("t2_accept", {31'd0, op_valid}, 32'd0);
        tick();
        chk("t2_pc_inc", {28'd0, pc}, 32'd1);
        tick(); tick(); tick();
        chk("t2_done", {27'd0, done, pc}, {27'd0, 1'b1, 4'd1});
        tick();

        // ---- BRZ target 4, z=1 then z=0; HALT beats BRZ
        load(4'd0, 16'h50CA);
        load(4'd4, 16'h8000);
        z_in = 1'b1;
        pulse_start(); tick(); tick(); tick();            // F I E F
        chk("t3_brz_z1_pc", {28'd0, pc}, BR_PC);
        tick(); tick(); tick();
        chk("t3_brz_z1_done", {27'd0, done, pc}, {27'd0, 1'b1, 4'(BR_PC)});
        tick();
        z_in = 1'b0;
        pulse_start(); tick(); tick(); tick();
        chk("t3_brz_z0_pc", {28'd0, pc}, 32'd1);
        tick(); tick(); tick();
        chk("t3_brz_z0_done", {27'd0, done, pc}, {27'd0, 1'b1, 4'd1});
        tick();
        load(4'd0, 16'hD0CA);
        z_in = 1'b1;
        pulse_start(); tick(); tick(); tick();            // F I E D
        chk("t3_halt_prio", {27'd0, done, pc}, {27'd0, 1'b1, 4'd0});
        tick();
        z_in = 1'b0;

        // ---- async reset while ISSUE at pc1
        load(4'd0, 16'h00CA);
        load(4'd1, 16'h01CB);
        pulse_start(); tick(); tick(); tick();            // F I E F(pc1)
        op_ready = 1'b0;
        tick();                                           // ISSUE pc1
        chk("t4_issue", {17'd0, pc, vec}, {17'd0, 4'd1, 11'h5CB});
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async", {15'd0, busy, pc, vec}, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        op_ready = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (op_valid) vld_seen++;
        end
        chk("t4_no_resume", vld_seen, 0);

        // ---- no HALT: pc wraps 15 -> 0; write+start same cycle; busy write ignored
        for (int i = 1; i < 16; i++) load(4'(i), 16'(i));
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'h0005; start = 1'b1;
        tick();                                           // FETCH reads new word
        load_en = 1'b0; start = 1'b0;
        beats = 0;
        for (int c = 0; c < 80 && beats < 18; c++) begin
            if (c == 0) begin
                load_en = 1'b1; load_addr = 4'd3; load_data = 16'h8000;
            end
            if (c == 2) load_en = 1'b0;
            tick();
            if (op_valid) begin
                seq[beats] = {pc, op2};
                beats++;
            end
        end
        load_en = 1'b0;
        chk("t5_beats", beats, 18);
        for (int k = 0; k < 18 && k < beats; k++) begin
            int a;
            a = k % 16;
            chk($sformatf("t5_beat%0d", k), {25'd0, seq[k]},
                {25'd0, 4'(a), (a == 0) ? 3'd5 : 3'(a & 7)});
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_start(); tick();                            // ISSUE mem0
        chk("t6_mem_persist", {21'd0, vec}, {21'd0, 1'b1, 4'd0, 3'd0, 3'd5});
        #2 rst_n = 1'b0;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PROG_AW, default 4, program-memory address width; depth = 2**PROG_AW words.
REQ-002 Parameter IW, default 16, instruction word width; fixed at 16.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, shared with the cpu, register file and RAM.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins execution at pc 0.
REQ-007 load_en  in  1  program-memory write strobe.
REQ-008 load_addr  in  PROG_AW  program-memory write address.
REQ-009 load_data  in  16  program-memory write data.
REQ-010 op  out  4  cpu operation code, driven to cpu Op.
REQ-011 op1  out  3  cpu operand-1 register address, driven to cpu Op1.
REQ-012 op2  out  3  cpu operand-2 register address, driven to cpu Op2.
REQ-013 op_valid  out  1  op/op1/op2 hold a valid instruction.
REQ-014 op_ready  in  1  cpu accepts the instruction on a clk edge with op_valid=1.
REQ-015 z_in  in  1  cpu Zero flag, sampled after acceptance.
REQ-016 pc  out  PROG_AW  current program counter.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on program completion.

Function
REQ-019 Instruction word layout: [3:0]=op2 bits? no -- [15]=HALT, [14]=BRZ, [13:10]=branch target, [9:6]=op, [5:3]=op1, [2:0]=op2.
REQ-020 FSM states: IDLE, FETCH, ISSUE, EVAL, DONE.
REQ-021 IDLE: start=1 -> FETCH, with pc set to 0 on the same edge.
REQ-022 FETCH: the instruction register captures mem[pc]; the FSM goes to ISSUE next cycle (1-cycle fetch latency).
REQ-023 ISSUE: op_valid=1 and op/op1/op2 are driven from the instruction register, stable until accepted.
REQ-024 ISSUE, edge with op_ready=1 -> EVAL; op_ready=0 holds ISSUE with no limit.
REQ-025 EVAL: op_valid=0; z_in is sampled this cycle; transitions are decided in REQ-026..REQ-028.
REQ-026 EVAL, HALT=1 -> DONE; HALT takes priority over BRZ.
REQ-027 EVAL, BRZ=1 and z_in=1 -> pc=target, then FETCH.
REQ-028 EVAL, any other case -> pc=pc+1 modulo 2**PROG_AW (15 wraps to 0), then FETCH.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; pc holds the address of the halting instruction.
REQ-030 start is ignored whenever busy=1.
REQ-031 load_en writes mem[load_addr] only in IDLE and is ignored while busy=1.
REQ-032 In IDLE, a write and a start in the same cycle: the write completes and FETCH reads the new word.
REQ-033 op/op1/op2 are 0 whenever op_valid=0.

Reset
REQ-034 rst_n=0 forces, asynchronously: state=IDLE, pc=0, instruction register=0, op=0, op1=0, op2=0, op_valid=0, busy=0, done=0.
REQ-035 Reset mid-operation abandons the instruction in flight; no further op_valid is asserted until a new start.
REQ-036 Program memory contents are not reset; they persist across rst_n.

Configuration
REQ-037 Macro SEQ_BRANCH_EN defined: BRZ is honoured per REQ-027.
REQ-038 Macro SEQ_BRANCH_EN undefined: bits [14:10] are ignored and EVAL always applies REQ-026 or REQ-028.

Structure
REQ-039 Shared package seq_pkg holds the FSM state enum, the instruction field bit positions and the PROG_AW default.
REQ-040 Sub-module seq_prog_mem holds the program memory: 2**PROG_AW x 16 array, synchronous write, combinational read.

Verification
REQ-041 Load mem[0]=0x00CA (op=0011, op1=1, op2=2), mem[1]=0x8000; pulse start -> one op_valid beat with op=3, op1=1, op2=2; then done pulse, pc=1.
REQ-042 Same program with op_ready held 0 for 5 cycles -> op_valid held and op/op1/op2 stable for 5 cycles; acceptance on the 6th.
REQ-043 SEQ_BRANCH_EN defined; mem[0]=0x5000|instr (BRZ, target 4); z_in=1 in EVAL -> next fetch at pc=4; with z_in=0 -> pc=1.
REQ-044 Reset asserted in ISSUE -> op_valid=0 and pc=0 immediately (asynchronous); start is ignored while busy.
REQ-045 Memory with no HALT, all BRZ=0 -> pc runs 15 then 0; load_en while busy leaves memory unchanged.
